// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode encodings and the control bundle layout
// consumed by the ID stage, the EX stage and the control unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic wen;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
    logic alusrc;
    logic illegal;
  } ctrl_t;

  // Instructions whose rt field is a source operand (not a destination).
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ)   || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/id_ctrl_dec.sv
// Combinational MIPS control decoder.
// Ports:
//   i_opcode  instr[31:26]
//   i_rt      instr[20:16]
//   i_rd      instr[15:11]
//   i_imm     instr[15:0]
//   o_ctrl    control bundle (illegal opcodes: only o_ctrl.illegal set)
//   o_dst     destination register (rd for R-type, 31 for jal, else rt)
//   o_imm     extended immediate
//   o_uses_rt rt is read as a source operand
module id_ctrl_dec
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [5:0]    i_opcode,
  input  logic [AW-1:0] i_rt,
  input  logic [AW-1:0] i_rd,
  input  logic [15:0]   i_imm,
  output ctrl_t         o_ctrl,
  output logic [AW-1:0] o_dst,
  output logic [DW-1:0] o_imm,
  output logic          o_uses_rt
);

  always_comb begin
    o_ctrl    = '0;
    o_dst     = i_rt;
    o_imm     = {{(DW-16){i_imm[15]}}, i_imm};
    o_uses_rt = uses_rt(i_opcode);
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.wen = 1'b1;
        o_dst      = i_rd;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        o_ctrl.wen    = 1'b1;
        o_ctrl.alusrc = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_ctrl.wen    = 1'b1;
        o_ctrl.alusrc = 1'b1;
        o_imm         = {{(DW-16){1'b0}}, i_imm};
      end
      OP_LUI: begin
        o_ctrl.wen    = 1'b1;
        o_ctrl.alusrc = 1'b1;
        o_imm         = {i_imm, {(DW-16){1'b0}}};
      end
      OP_LW: begin
        o_ctrl.wen     = 1'b1;
        o_ctrl.memread = 1'b1;
        o_ctrl.alusrc  = 1'b1;
      end
      OP_SW: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
      end
      OP_BEQ, OP_BNE: o_ctrl.branch = 1'b1;
      OP_J:           o_ctrl.jump   = 1'b1;
      OP_JAL: begin
        o_ctrl.wen  = 1'b1;
        o_ctrl.jump = 1'b1;
        o_dst       = AW'(31);
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage with ID/EX pipeline register.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_if_valid, i_instr, i_pc4    instruction from IF
//   i_flush                       taken branch/jump in EX kills the ID instruction
//   o_stall                       IF must hold its instruction (load-use hazard)
//   o_raddr1/2, i_rdata1/2        regFile read port (rs, rt)
//   i_wb_we/waddr/wdata           WB write port, bypassed into the operands
//   o_ex_*                        registered ID/EX contents
module id_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_valid,
  input  logic [31:0]   i_instr,
  input  logic [31:0]   i_pc4,
  input  logic          i_flush,
  output logic          o_stall,
  output logic [AW-1:0] o_raddr1,
  output logic [AW-1:0] o_raddr2,
  input  logic [DW-1:0] i_rdata1,
  input  logic [DW-1:0] i_rdata2,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_waddr,
  input  logic [DW-1:0] i_wb_wdata,
  output logic          o_ex_valid,
  output logic [31:0]   o_ex_pc4,
  output logic [DW-1:0] o_ex_rs_val,
  output logic [DW-1:0] o_ex_rt_val,
  output logic [DW-1:0] o_ex_imm,
  output logic [AW-1:0] o_ex_rs,
  output logic [AW-1:0] o_ex_rt,
  output logic [AW-1:0] o_ex_dst,
  output logic          o_ex_wen,
  output logic          o_ex_memread,
  output logic          o_ex_memwrite,
  output logic          o_ex_branch,
  output logic          o_ex_jump,
  output logic          o_ex_alusrc,
  output logic [5:0]    o_ex_opcode,
  output logic [5:0]    o_ex_funct,
  output logic          o_ex_illegal
);

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc4;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    ctrl_t         ctrl;
    logic [5:0]    opcode;
    logic [5:0]    funct;
  } idex_t;

  idex_t idex_d, idex_q;

  logic [5:0]    opcode;
  logic [AW-1:0] rs, rt;
  ctrl_t         dec_ctrl;
  logic [AW-1:0] dec_dst;
  logic [DW-1:0] dec_imm;
  logic          dec_uses_rt;
  logic          hazard;

  // shamt is decoded downstream from funct-class instructions; ID ignores it.
  logic unused_shamt;
  assign unused_shamt = ^i_instr[10:6];

  assign opcode   = i_instr[31:26];
  assign rs       = i_instr[25:21];
  assign rt       = i_instr[20:16];
  assign o_raddr1 = rs;
  assign o_raddr2 = rt;

  id_ctrl_dec #(
    .DW (DW),
    .AW (AW)
  ) u_dec (
    .i_opcode  (opcode),
    .i_rt      (rt),
    .i_rd      (i_instr[15:11]),
    .i_imm     (i_instr[15:0]),
    .o_ctrl    (dec_ctrl),
    .o_dst     (dec_dst),
    .o_imm     (dec_imm),
    .o_uses_rt (dec_uses_rt)
  );

  // regFile commits on the same edge ID/EX captures, so a same-cycle WB
  // write must be taken from the WB port rather than the stale read data.
  function automatic logic [DW-1:0] operand(input logic [AW-1:0] addr,
                                            input logic [DW-1:0] rdata,
                                            input logic          wb_we,
                                            input logic [AW-1:0] wb_waddr,
                                            input logic [DW-1:0] wb_wdata);
    if (addr == '0)                    return '0;
    else if (wb_we && wb_waddr == addr) return wb_wdata;
    else                               return rdata;
  endfunction

  always_comb begin
    hazard = i_if_valid && idex_q.valid && idex_q.ctrl.memread &&
             (idex_q.dst != '0) &&
             ((rs == idex_q.dst) || (dec_uses_rt && (rt == idex_q.dst)));

    // Flush overrides the hazard: the instruction is killed and IF refetches.
    o_stall = hazard && !i_flush && !i_rst;

    idex_d = '0;
    if (!i_flush && !hazard && i_if_valid) begin
      idex_d.valid  = 1'b1;
      idex_d.pc4    = i_pc4;
      idex_d.rs_val = operand(rs, i_rdata1, i_wb_we, i_wb_waddr, i_wb_wdata);
      idex_d.rt_val = operand(rt, i_rdata2, i_wb_we, i_wb_waddr, i_wb_wdata);
      idex_d.imm    = dec_imm;
      idex_d.rs     = rs;
      idex_d.rt     = rt;
      idex_d.dst    = dec_dst;
      idex_d.ctrl   = dec_ctrl;
      idex_d.opcode = opcode;
      idex_d.funct  = i_instr[5:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign o_ex_valid    = idex_q.valid;
  assign o_ex_pc4      = idex_q.pc4;
  assign o_ex_rs_val   = idex_q.rs_val;
  assign o_ex_rt_val   = idex_q.rt_val;
  assign o_ex_imm      = idex_q.imm;
  assign o_ex_rs       = idex_q.rs;
  assign o_ex_rt       = idex_q.rt;
  assign o_ex_dst      = idex_q.dst;
  assign o_ex_wen      = idex_q.ctrl.wen;
  assign o_ex_memread  = idex_q.ctrl.memread;
  assign o_ex_memwrite = idex_q.ctrl.memwrite;
  assign o_ex_branch   = idex_q.ctrl.branch;
  assign o_ex_jump     = idex_q.ctrl.jump;
  assign o_ex_alusrc   = idex_q.ctrl.alusrc;
  assign o_ex_opcode   = idex_q.opcode;
  assign o_ex_funct    = idex_q.funct;
  assign o_ex_illegal  = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver issues instructions and pushes the
// expected stall and ID/EX contents; two monitors pop and compare.
module tb_id_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, if_valid = 1'b0, flush = 1'b0;
  logic [31:0] instr = '0, pc4 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        stall;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_valid, ex_wen, ex_mr, ex_mw, ex_br, ex_j, ex_as, ex_ill;
  logic [31:0] ex_pc4, ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [5:0]  ex_op, ex_fn;

  id_stage #(.DW(32), .AW(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .i_instr(instr), .i_pc4(pc4),
    .i_flush(flush), .o_stall(stall), .o_raddr1(raddr1), .o_raddr2(raddr2),
    .i_rdata1(rdata1), .i_rdata2(rdata2), .i_wb_we(wb_we), .i_wb_waddr(wb_waddr),
    .i_wb_wdata(wb_wdata), .o_ex_valid(ex_valid), .o_ex_pc4(ex_pc4),
    .o_ex_rs_val(ex_rs_val), .o_ex_rt_val(ex_rt_val), .o_ex_imm(ex_imm),
    .o_ex_rs(ex_rs), .o_ex_rt(ex_rt), .o_ex_dst(ex_dst), .o_ex_wen(ex_wen),
    .o_ex_memread(ex_mr), .o_ex_memwrite(ex_mw), .o_ex_branch(ex_br),
    .o_ex_jump(ex_j), .o_ex_alusrc(ex_as), .o_ex_opcode(ex_op),
    .o_ex_funct(ex_fn), .o_ex_illegal(ex_ill)
  );

  // Environment register file: writes commit at the clock edge, reads are combinational.
  logic [31:0] rf [32];
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_waddr != 5'd0) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4, rs_val, rt_val, imm;
    logic [4:0]  rs, rt, dst;
    logic        wen, mr, mw, br, j, as, ill;
    logic [5:0]  op, fn;
  } exp_t;

  exp_t exp_q[$];
  logic stall_q[$];
  exp_t m_ex = '0;   // model's view of what EX holds
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
    else n_pass++;
  endtask

  // Value a source register will hold once this edge's WB write lands.
  function automatic logic [31:0] reg_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_waddr == a) return wb_wdata;
    return rf[a];
  endfunction

  function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op;
    logic [5:0] c;  // wen memread memwrite branch jump alusrc
    logic [15:0] im;
    op = ins[31:26];
    im = ins[15:0];
    e = '0;
    e.valid = 1'b1; e.pc4 = pc; e.op = op; e.fn = ins[5:0];
    e.rs = ins[25:21]; e.rt = ins[20:16];
    e.rs_val = reg_val(ins[25:21]); e.rt_val = reg_val(ins[20:16]);
    e.dst = (op == 6'h00) ? ins[15:11] : (op == 6'h03) ? 5'd31 : ins[20:16];
    if (op >= 6'h0C && op <= 6'h0E) e.imm = {16'h0, im};
    else if (op == 6'h0F)           e.imm = {im, 16'h0};
    else                            e.imm = {{16{im[15]}}, im};
    c = 6'b000000;
    case (op)
      6'h00:                                           c = 6'b100000;
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: c = 6'b100001;
      6'h23:                                           c = 6'b110001;
      6'h2B:                                           c = 6'b001001;
      6'h04, 6'h05:                                    c = 6'b000100;
      6'h02:                                           c = 6'b000010;
      6'h03:                                           c = 6'b100010;
      default:                                         e.ill = 1'b1;
    endcase
    {e.wen, e.mr, e.mw, e.br, e.j, e.as} = c;
    return e;
  endfunction

  // One clock cycle of stimulus; returns whether the model expects a stall.
  task automatic step(input logic r, input logic fl, input logic v, input logic [31:0] ins,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      output logic stalled);
    logic haz, rt_src;
    exp_t nxt;
    @(negedge clk);
    rst = r; flush = fl; if_valid = v; instr = ins; pc4 = pc4 + 32'd4;
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    rt_src = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) ||
             (ins[31:26] == 6'h04) || (ins[31:26] == 6'h05);
    haz = v && m_ex.valid && m_ex.mr && m_ex.dst != 5'd0 &&
          (ins[25:21] == m_ex.dst || (rt_src && ins[20:16] == m_ex.dst));
    stalled = 1'b0;
    if (r || fl || !v) nxt = '0;
    else if (haz) begin nxt = '0; stalled = 1'b1; end
    else nxt = decode(ins, pc4);
    stall_q.push_back(stalled);
    exp_q.push_back(nxt);
    m_ex = nxt;
  endtask

  // Present an instruction until IF is allowed to move on.
  task automatic issue(input logic [31:0] ins, input logic fl, input logic rnd_wb);
    logic st;
    int   tries;
    tries = 0;
    do begin
      if (rnd_wb)
        step(1'b0, fl, 1'b1, ins, 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom, st);
      else
        step(1'b0, fl, 1'b1, ins, 1'b0, 5'd0, 32'd0, st);
      tries++;
    end while (st && tries < 3);
    n_chk++;
    if (st) $display("FAIL stall_bound: model still stalled after %0d cycles", tries);
    else n_pass++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [17];
    logic [31:0] w;
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    w = $urandom;
    w[31:26] = ops[$urandom_range(16)];
    w[25:21] = 5'($urandom_range(7));
    w[20:16] = 5'($urandom_range(7));
    w[15:11] = 5'($urandom_range(7));
    return w;
  endfunction

  // Stall monitor: o_stall is combinational, sampled late in the low phase.
  initial forever begin
    @(negedge clk); #4;
    if (stall_q.size() > 0) chk("o_stall", 32'(stall), 32'(stall_q.pop_front()));
  end

  // ID/EX monitor: sampled just after the capturing edge.
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ex_valid", 32'(ex_valid), 32'(e.valid));
      chk("ex_pc4", ex_pc4, e.pc4);
      chk("ex_rs_val", ex_rs_val, e.rs_val);
      chk("ex_rt_val", ex_rt_val, e.rt_val);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_rs", 32'(ex_rs), 32'(e.rs));
      chk("ex_rt", 32'(ex_rt), 32'(e.rt));
      chk("ex_dst", 32'(ex_dst), 32'(e.dst));
      chk("ex_ctrl", 32'({ex_wen, ex_mr, ex_mw, ex_br, ex_j, ex_as, ex_ill}),
          32'({e.wen, e.mr, e.mw, e.br, e.j, e.as, e.ill}));
      chk("ex_opcode", 32'(ex_op), 32'(e.op));
      chk("ex_funct", 32'(ex_fn), 32'(e.fn));
    end
  end

  initial begin
    logic st;
    // Reset held two cycles with a valid addi presented.
    step(1'b1, 1'b0, 1'b1, 32'h2001FFFB, 1'b0, 5'd0, 32'd0, st);
    step(1'b1, 1'b0, 1'b1, 32'h2001FFFB, 1'b0, 5'd0, 32'd0, st);
    // Immediate extension.
    issue(32'h2001FFFB, 1'b0, 1'b0);   // addi r1,r0,-5
    issue(32'h3401FFFB, 1'b0, 1'b0);   // ori  r1,r0,0xFFFB
    issue(32'h3C01ABCD, 1'b0, 1'b0);   // lui  r1,0xABCD
    // WB write-through: r3 written while add r4,r3,r3 is in ID.
    step(1'b0, 1'b0, 1'b1, 32'h00632020, 1'b1, 5'd3, 32'h00001234, st);
    // Load-use: lw r2 then add r5,r2,r1 / sw r2,0(r1) / addi r5,r0,1.
    issue(32'h8C020000, 1'b0, 1'b0);
    issue(32'h00412820, 1'b0, 1'b0);
    issue(32'h8C020000, 1'b0, 1'b0);
    issue(32'hAC220000, 1'b0, 1'b0);
    issue(32'h8C020000, 1'b0, 1'b0);
    issue(32'h20050001, 1'b0, 1'b0);
    // Load into r0 never stalls.
    issue(32'h8C000000, 1'b0, 1'b0);
    issue(32'h00002820, 1'b0, 1'b0);
    // Flush beats hazard; reset beats flush.
    issue(32'h8C020000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h00412820, 1'b0, 5'd0, 32'd0, st);
    issue(32'h8C020000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h00412820, 1'b0, 5'd0, 32'd0, st);
    // Illegal opcode and jal.
    issue(32'hFC000000, 1'b0, 1'b0);
    issue(32'h0C000010, 1'b0, 1'b0);
    // Invalid IF slot loads as a bubble.
    step(1'b0, 1'b0, 1'b0, 32'h8C020000, 1'b0, 5'd0, 32'd0, st);
    // Randomized traffic with WB writes, flushes and bubbles.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(9) == 0)
        step(1'b0, 1'b0, 1'b0, rand_instr(), 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom, st);
      else
        issue(rand_instr(), ($urandom_range(9) == 0), 1'b1);
    end
    @(negedge clk);
    if_valid = 1'b0; wb_we = 1'b0; flush = 1'b0;
    for (int i = 0; i < 10 && (exp_q.size() > 0 || stall_q.size() > 0); i++) @(posedge clk);
    #5;
    n_chk++;
    if (exp_q.size() > 0 || stall_q.size() > 0)
      $display("FAIL drain: %0d ex / %0d stall expectations left, required 0", exp_q.size(), stall_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
